hub75_rx: RTL and testbench
===========================

HUB75_RX -- requirements
Module: hub75_rx

Interface
REQ-001 SHALL have parameter COLOR_DEPTH, default 6, the number of BCM bit planes per row (1..8).
REQ-002 SHALL have parameter CHAINED, default 2, the number of 64-wide panels chained; WIDTH = 64*CHAINED columns.
REQ-003 SHALL have port ctrl_clk, input, 1 bit, the single clock; the sample clock is at least 4x the panel_clk toggle rate.
REQ-004 SHALL have port ctrl_rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have ports panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1, each input, 1 bit, HUB75 colour data (upper and lower half), asynchronous.
REQ-006 SHALL have ports panel_a, panel_b, panel_c, panel_d, panel_e, each input, 1 bit, the row select, panel_e as MSB, asynchronous.
REQ-007 SHALL have ports panel_clk, panel_stb and panel_oe, each input, 1 bit, the shift clock, the latch (active high) and the output enable (active low, ignored), asynchronous.
REQ-008 SHALL have port out_valid, output, 1 bit, pixel write valid.
REQ-009 SHALL have port out_ready, input, 1 bit, consumer accepts the current write.
REQ-010 SHALL have port out_addr, output, 6+log2(WIDTH) bits, {y[5:0], x}.
REQ-011 SHALL have port out_wdat, output, 24 bits, [R][G][B] bytes, each holding the value in bits [COLOR_DEPTH-1:0] with upper bits zero.
REQ-012 SHALL have port row_done, output, 1 bit, a one-cycle pulse after the last write of a row pair.
REQ-013 SHALL have port err_overflow, output, 1 bit, sticky: more than WIDTH clocks seen between strobes.
REQ-014 SHALL have port err_overrun, output, 1 bit, sticky: data was dropped because the internal FSM was busy.

Function
REQ-015 SHALL pass every panel_* input through a 2-FF synchronizer, followed by one edge-detect register; an input edge is acted on 3 ctrl_clk cycles after it occurs.
REQ-016 SHALL, on each panel_clk rising edge, write the 6 colour bits into the active stage bank at column k and then increment k; k is reset to 0 by a strobe.
REQ-017 SHALL, on a panel_clk edge with k == WIDTH, discard the data and set err_overflow.
REQ-018 SHALL, on a strobe with k < WIDTH, leave columns k..WIDTH-1 of the bank holding stale data, with no error raised.
REQ-019 SHALL, on each panel_stb rising edge, sample row = {e,d,c,b,a}.
REQ-020 SHALL, on that strobe, set plane = 0 if row != last_row; otherwise set plane = plane+1, saturating at COLOR_DEPTH-1.
REQ-021 SHALL, on that strobe, update last_row and toggle the stage bank.
REQ-022 SHALL implement an FSM with states IDLE, COMMIT and EMIT.
REQ-023 SHALL transition IDLE->COMMIT on a strobe.
REQ-024 SHALL, in COMMIT, copy one column per cycle (WIDTH cycles) from the retired bank into accumulator bit [plane] for all 6 channels; plane 0 clears the other bits.
REQ-025 SHALL transition COMMIT->EMIT when plane == COLOR_DEPTH-1, and COMMIT->IDLE otherwise.
REQ-026 SHALL, in EMIT, present 2*WIDTH writes: for x = 0..WIDTH-1, first y=row with (r0,g0,b0), then y=row+32 with (r1,g1,b1).
REQ-027 SHALL, in EMIT, advance to the next write only on the cycle where out_valid && out_ready, and SHALL hold out_addr and out_wdat stable while out_valid && !out_ready.
REQ-028 SHALL, after the final accepted write, pulse row_done for one cycle and go to IDLE.
REQ-029 SHALL, on a strobe arriving while in COMMIT or EMIT, still toggle the bank and update plane/last_row, but SHALL NOT commit that bank; SHALL set err_overrun.
REQ-030 SHALL, on a strobe arriving while in COMMIT or EMIT, make the row in progress finish normally.
REQ-031 SHALL treat a panel_clk edge and a strobe edge detected in the same cycle as the clock first, then the strobe.

Reset
REQ-032 SHALL, while ctrl_rst is high, clear immediately: out_valid=0, out_addr=0, out_wdat=0, row_done=0, err_overflow=0, err_overrun=0, FSM=IDLE, k=0, plane=0, last_row=0, bank=0, synchronizer flops=0.
REQ-033 SHALL leave the stage and accumulator contents undefined after reset; no write is emitted from them until after a plane-0 commit.
REQ-034 SHALL, if reset is asserted mid-EMIT, drop out_valid asynchronously; no further writes come from that row.

Verification
REQ-035 SHALL be covered by a bench where one row (row=3, WIDTH=128) is sent as 6 planes encoding pixel x = x mod 64 on all channels with out_ready=1 -> 256 writes, addr {3,x} and {35,x}, wdat = {x mod 64} replicated in R, G and B, and row_done pulses once.
REQ-036 SHALL be covered by a bench where out_ready toggles 1/0 every cycle during EMIT -> the write sequence is identical to the out_ready=1 case, and out_addr/out_wdat never change while stalled.
REQ-037 SHALL be covered by a bench where 130 panel_clk pulses precede a strobe -> err_overflow=1, and columns 0..127 hold the first 128 bits.
REQ-038 SHALL be covered by a bench where the row changes from 3 to 4 after only 2 planes -> plane resets to 0 and no writes are emitted for row 3.
REQ-039 SHALL be covered by a bench where a strobe is sent 10 cycles after entering EMIT -> err_overrun=1, and the current row's 256 writes are still complete.
REQ-040 SHALL be covered by a bench where ctrl_rst pulses mid-EMIT -> out_valid=0 in the same cycle, all flags are 0, and the next full row is captured correctly.

Source files
------------

// File: rtl/hub75_rx.sv
// HUB75 panel receiver: it oversamples the shift bus, builds BCM bit planes into a
// per-pixel accumulator, and emits each completed row pair as addressed pixel writes.
module hub75_rx #(
    parameter int COLOR_DEPTH = 6,
    parameter int CHAINED     = 2
) (
    input  logic                                   ctrl_clk,
    input  logic                                   ctrl_rst,
    input  logic                                   panel_r0,
    input  logic                                   panel_g0,
    input  logic                                   panel_b0,
    input  logic                                   panel_r1,
    input  logic                                   panel_g1,
    input  logic                                   panel_b1,
    input  logic                                   panel_a,
    input  logic                                   panel_b,
    input  logic                                   panel_c,
    input  logic                                   panel_d,
    input  logic                                   panel_e,
    input  logic                                   panel_clk,
    input  logic                                   panel_stb,
    input  logic                                   panel_oe,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [6+$clog2(64*CHAINED)-1:0]        out_addr,
    output logic [23:0]                            out_wdat,
    output logic                                   row_done,
    output logic                                   err_overflow,
    output logic                                   err_overrun
);

    localparam int WIDTH = 64 * CHAINED;
    localparam int XW    = $clog2(WIDTH);
    localparam int PW    = (COLOR_DEPTH > 1) ? $clog2(COLOR_DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PLANE = PW'(COLOR_DEPTH - 1);
    localparam logic [XW:0]   K_FULL     = (XW+1)'(WIDTH);
    localparam logic [XW:0]   LAST_IDX   = (XW+1)'(2 * WIDTH - 1);
    localparam logic [XW-1:0] LAST_COL   = XW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, COMMIT, EMIT} state_t;

    logic [13:0] raw_in;
    logic [13:0] meta_q;
    logic [13:0] sync_q;
    logic        clk_q;
    logic        stb_q;
    logic        clk_rise;
    logic        stb_rise;
    logic [5:0]  pix_in;
    logic [4:0]  row_in;
    logic        unused_oe;

    state_t          state;
    logic [XW:0]     k;
    logic [PW-1:0]   plane;
    logic [PW-1:0]   plane_next;
    logic [4:0]      last_row;
    logic            bank;
    logic            cm_bank;
    logic [PW-1:0]   cm_plane;
    logic [4:0]      cm_row;
    logic [XW-1:0]   col;
    logic [XW:0]     idx;
    logic            acc_valid;

    logic [5:0]                   stage [2][WIDTH];
    logic [5:0][COLOR_DEPTH-1:0]  acc   [WIDTH];
    logic [5:0][COLOR_DEPTH-1:0]  commit_word;
    logic [5:0][COLOR_DEPTH-1:0]  emit_chans;

    logic [XW:0]             nxt_idx;
    logic [XW-1:0]           nxt_x;
    logic                    nxt_lo;
    logic [6+XW-1:0]         emit_addr;
    logic [23:0]             emit_wdat;

    // Channel order in every 6-bit word: [5]=r0 [4]=g0 [3]=b0 [2]=r1 [1]=g1 [0]=b1.
    assign raw_in = {panel_oe, panel_stb, panel_clk,
                     panel_e, panel_d, panel_c, panel_b, panel_a,
                     panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1};

    always_ff @(posedge ctrl_clk or posedge ctrl_rst) begin
        if (ctrl_rst) begin
            meta_q <= '0;
            sync_q <= '0;
            clk_q  <= 1'b0;
            stb_q  <= 1'b0;
        end else begin
            meta_q <= raw_in;
            sync_q <= meta_q;
            clk_q  <= sync_q[11];
            stb_q  <= sync_q[12];
        end
    end

    assign clk_rise  = sync_q[11] & ~clk_q;
    assign stb_rise  = sync_q[12] & ~stb_q;
    assign pix_in    = sync_q[5:0];
    assign row_in    = sync_q[10:6];
    assign unused_oe = sync_q[13];

    always_comb begin
        plane_next = plane;
        if (row_in != last_row)
            plane_next = '0;
        else if (plane != LAST_PLANE)
            plane_next = plane + 1'b1;
    end

    always_comb begin
        commit_word = (cm_plane == '0) ? '0 : acc[col];
        for (int ch = 0; ch < 6; ch++)
            commit_word[ch][cm_plane] = stage[cm_bank][col][ch];
    end

    // Output registers are always loaded with the write that follows the current one.
    always_comb begin
        nxt_idx    = (state == EMIT) ? idx + 1'b1 : '0;
        nxt_x      = nxt_idx[XW:1];
        nxt_lo     = nxt_idx[0];
        emit_chans = acc[nxt_x];
        emit_addr  = {nxt_lo, cm_row, nxt_x};
        if (nxt_lo)
            emit_wdat = {8'(emit_chans[2]), 8'(emit_chans[1]), 8'(emit_chans[0])};
        else
            emit_wdat = {8'(emit_chans[5]), 8'(emit_chans[4]), 8'(emit_chans[3])};
    end

    always_ff @(posedge ctrl_clk) begin
        if (clk_rise && k != K_FULL)
            stage[bank][k[XW-1:0]] <= pix_in;
        if (state == COMMIT)
            acc[col] <= commit_word;
    end

    // A clock and strobe in the same cycle: the column write above uses the old bank and k.
    always_ff @(posedge ctrl_clk or posedge ctrl_rst) begin
        if (ctrl_rst) begin
            state        <= IDLE;
            k            <= '0;
            plane        <= '0;
            last_row     <= '0;
            bank         <= 1'b0;
            cm_bank      <= 1'b0;
            cm_plane     <= '0;
            cm_row       <= '0;
            col          <= '0;
            idx          <= '0;
            acc_valid    <= 1'b0;
            out_valid    <= 1'b0;
            out_addr     <= '0;
            out_wdat     <= '0;
            row_done     <= 1'b0;
            err_overflow <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            row_done <= 1'b0;
            if (clk_rise) begin
                if (k == K_FULL)
                    err_overflow <= 1'b1;
                else
                    k <= k + 1'b1;
            end
            if (stb_rise) begin
                k        <= '0;
                plane    <= plane_next;
                last_row <= row_in;
                bank     <= ~bank;
                if (state != IDLE)
                    err_overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (stb_rise) begin
                        cm_bank  <= bank;
                        cm_plane <= plane_next;
                        cm_row   <= row_in;
                        col      <= '0;
                        if (plane_next == '0)
                            acc_valid <= 1'b1;
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    col <= col + 1'b1;
                    if (col == LAST_COL) begin
                        if (cm_plane == LAST_PLANE && acc_valid) begin
                            state     <= EMIT;
                            idx       <= '0;
                            out_valid <= 1'b1;
                            out_addr  <= emit_addr;
                            out_wdat  <= emit_wdat;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (idx == LAST_IDX) begin
                            out_valid <= 1'b0;
                            row_done  <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            idx      <= idx + 1'b1;
                            out_addr <= emit_addr;
                            out_wdat <= emit_wdat;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_rx.sv
// Directed bench for hub75_rx: drives whole HUB75 rows and checks the emitted pixel writes.
module tb_hub75_rx;

    localparam int WIDTH = 128;

    logic        ctrl_clk, ctrl_rst;
    logic        panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1;
    logic        panel_a, panel_b, panel_c, panel_d, panel_e;
    logic        panel_clk, panel_stb, panel_oe;
    logic        out_valid, out_ready, row_done, err_overflow, err_overrun;
    logic [12:0] out_addr;
    logic [23:0] out_wdat;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [12:0] got_addr[$];
    logic [23:0] got_wdat[$];
    int          rd_cnt = 0;
    int          stall_seen = 0;
    bit          toggle_mode = 0;
    bit          stall_prev = 0;
    logic [36:0] stall_val;

    hub75_rx #(.COLOR_DEPTH(6), .CHAINED(2)) dut (
        .ctrl_clk(ctrl_clk), .ctrl_rst(ctrl_rst),
        .panel_r0(panel_r0), .panel_g0(panel_g0), .panel_b0(panel_b0),
        .panel_r1(panel_r1), .panel_g1(panel_g1), .panel_b1(panel_b1),
        .panel_a(panel_a), .panel_b(panel_b), .panel_c(panel_c),
        .panel_d(panel_d), .panel_e(panel_e),
        .panel_clk(panel_clk), .panel_stb(panel_stb), .panel_oe(panel_oe),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_wdat(out_wdat), .row_done(row_done),
        .err_overflow(err_overflow), .err_overrun(err_overrun)
    );

    initial begin
        ctrl_clk = 1'b0;
        forever #5 ctrl_clk = ~ctrl_clk;
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge ctrl_clk);
            #1;
            out_ready = toggle_mode ? ~out_ready : 1'b1;
        end
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Records accepted writes and verifies outputs hold while stalled.
    always @(negedge ctrl_clk) begin
        if (!ctrl_rst) begin
            if (stall_prev)
                check_output("stall_hold", {26'd0, out_valid, out_addr, out_wdat},
                             {26'd0, 1'b1, stall_val});
            if (out_valid && out_ready) begin
                got_addr.push_back(out_addr);
                got_wdat.push_back(out_wdat);
            end
            if (row_done) rd_cnt++;
            if (out_valid && !out_ready) stall_seen++;
            stall_prev = out_valid && !out_ready;
            stall_val  = {out_addr, out_wdat};
        end else begin
            stall_prev = 0;
        end
    end

    task automatic clear_log();
        got_addr.delete();
        got_wdat.delete();
        rd_cnt     = 0;
        stall_seen = 0;
    endtask

    task automatic apply_reset();
        ctrl_rst = 1'b1;
        {panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1} = '0;
        {panel_e, panel_d, panel_c, panel_b, panel_a} = '0;
        panel_clk = 1'b0; panel_stb = 1'b0; panel_oe = 1'b1;
        toggle_mode = 0;
        repeat (3) @(negedge ctrl_clk);
        ctrl_rst = 1'b0;
        repeat (3) @(negedge ctrl_clk);
        clear_log();
    endtask

    task automatic shift_col(input logic [5:0] d);
        @(negedge ctrl_clk);
        {panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1} = d;
        panel_clk = 1'b0;
        repeat (3) @(negedge ctrl_clk);
        panel_clk = 1'b1;
        repeat (3) @(negedge ctrl_clk);
        panel_clk = 1'b0;
    endtask

    task automatic strobe_row(input logic [4:0] row);
        {panel_e, panel_d, panel_c, panel_b, panel_a} = row;
        repeat (2) @(negedge ctrl_clk);
        panel_stb = 1'b1;
        repeat (3) @(negedge ctrl_clk);
        panel_stb = 1'b0;
        repeat (3) @(negedge ctrl_clk);
    endtask

    // Pixel x carries x mod 64; columns beyond the panel width carry all ones.
    task automatic apply_stimulus(input logic [4:0] row, input int p, input int ncols);
        logic [5:0] v;
        for (int x = 0; x < ncols; x++) begin
            v = 6'(x % 64);
            shift_col((x >= WIDTH) ? 6'h3F : {6{v[p]}});
        end
        strobe_row(row);
    endtask

    task automatic send_row(input logic [4:0] row);
        for (int p = 0; p < 6; p++) apply_stimulus(row, p, WIDTH);
    endtask

    task automatic wait_row_done(input string tag);
        int start = rd_cnt;
        int n = 0;
        while (rd_cnt == start && n < 3000) begin
            @(negedge ctrl_clk);
            n++;
        end
        check_output({tag, "_done"}, 64'(rd_cnt != start), 64'd1);
        repeat (20) @(negedge ctrl_clk);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 3000) begin
            @(negedge ctrl_clk);
            n++;
        end
        check_output({tag, "_emit"}, 64'(out_valid), 64'd1);
    endtask

    task automatic check_row(input logic [4:0] row, input string tag);
        logic [5:0]  v;
        logic [12:0] ea;
        logic [23:0] ew;
        int          x;
        check_output({tag, "_count"}, 64'(got_addr.size()), 64'd256);
        for (int i = 0; i < got_addr.size() && i < 256; i++) begin
            x  = i / 2;
            v  = 6'(x % 64);
            ea = {(i % 2 == 1), row, 7'(x)};
            ew = {2'b00, v, 2'b00, v, 2'b00, v};
            check_output($sformatf("%s_w%0d", tag, i), {27'd0, got_addr[i], got_wdat[i]},
                         {27'd0, ea, ew});
        end
    endtask

    initial begin
        // Reset values
        apply_reset();
        check_output("rst_valid", 64'(out_valid), 64'd0);
        check_output("rst_addr", 64'(out_addr), 64'd0);
        check_output("rst_wdat", 64'(out_wdat), 64'd0);
        check_output("rst_done", 64'(row_done), 64'd0);
        check_output("rst_ovf", 64'(err_overflow), 64'd0);
        check_output("rst_ovr", 64'(err_overrun), 64'd0);

        // Full row 3, consumer always ready
        send_row(5'd3);
        wait_row_done("basic");
        check_row(5'd3, "basic");
        check_output("basic_rdcnt", 64'(rd_cnt), 64'd1);
        check_output("basic_ovf", 64'(err_overflow), 64'd0);
        check_output("basic_ovr", 64'(err_overrun), 64'd0);

        // Consumer ready toggles every cycle
        apply_reset();
        toggle_mode = 1;
        send_row(5'd3);
        wait_row_done("stall");
        toggle_mode = 0;
        check_row(5'd3, "stall");
        check_output("stall_seen", 64'(stall_seen > 0), 64'd1);
        check_output("stall_rdcnt", 64'(rd_cnt), 64'd1);

        // 130 shift clocks before the first strobe; extra columns are all ones
        apply_reset();
        apply_stimulus(5'd3, 0, WIDTH + 2);
        check_output("ovf_flag", 64'(err_overflow), 64'd1);
        for (int p = 1; p < 6; p++) apply_stimulus(5'd3, p, WIDTH);
        wait_row_done("ovf");
        check_row(5'd3, "ovf");
        check_output("ovf_ovr", 64'(err_overrun), 64'd0);

        // Row 3 abandoned after 2 planes, then row 4 sent in full
        apply_reset();
        apply_stimulus(5'd3, 0, WIDTH);
        apply_stimulus(5'd3, 1, WIDTH);
        repeat (300) @(negedge ctrl_clk);
        check_output("chg_nowrites", 64'(got_addr.size()), 64'd0);
        send_row(5'd4);
        wait_row_done("chg");
        check_row(5'd4, "chg");
        check_output("chg_rdcnt", 64'(rd_cnt), 64'd1);

        // Strobe during EMIT
        apply_reset();
        send_row(5'd3);
        wait_valid("ovr");
        repeat (10) @(negedge ctrl_clk);
        strobe_row(5'd3);
        wait_row_done("ovr");
        check_output("ovr_flag", 64'(err_overrun), 64'd1);
        check_row(5'd3, "ovr");
        check_output("ovr_rdcnt", 64'(rd_cnt), 64'd1);

        // Reset pulse mid-EMIT after raising an overrun
        apply_reset();
        send_row(5'd3);
        wait_valid("mrst");
        strobe_row(5'd3);
        check_output("mrst_pre_ovr", 64'(err_overrun), 64'd1);
        check_output("mrst_pre_valid", 64'(out_valid), 64'd1);
        #2;
        ctrl_rst = 1'b1;
        #1;
        check_output("mrst_valid", 64'(out_valid), 64'd0);
        check_output("mrst_ovr", 64'(err_overrun), 64'd0);
        check_output("mrst_ovf", 64'(err_overflow), 64'd0);
        check_output("mrst_done", 64'(row_done), 64'd0);
        check_output("mrst_addr", 64'(out_addr), 64'd0);
        repeat (2) @(negedge ctrl_clk);
        ctrl_rst = 1'b0;
        repeat (3) @(negedge ctrl_clk);
        clear_log();
        send_row(5'd5);
        wait_row_done("mrst");
        check_row(5'd5, "mrst");
        check_output("mrst_rdcnt", 64'(rd_cnt), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
